// File: rtl/multi_phase_addr_gen_if.sv
// ---------------------------------------------------------------------------
// multi_phase_addr_gen_if
//
// Control/status bundle for the multi-phase ROM address generator.
//
// Signals (direction as seen by the generator, i.e. the slave modport):
//   en        in   advance enable; low holds accumulator, direction and state
//   step      in   unsigned phase increment, LSB = 2^-FRAC_WIDTH address
//   mode      in   00 wrap, 01 ping-pong, 10 one-shot, 11 hold
//   start     in   arms a one-shot burst (mode 10 only)
//   ofs_wr    in   offset write strobe
//   ofs_ch    in   offset channel select
//   ofs_data  in   offset value to write
//   addr      out  packed channel addresses, channel k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   wrap      out  one-cycle pulse on wrap / turnaround / burst end
//   busy      out  high while a one-shot burst runs
//   done      out  one-cycle pulse when a one-shot burst completes
//
// The master modport belongs to whoever drives the controls (a sequencer or a
// testbench); the slave modport is used by the generator itself.
// ---------------------------------------------------------------------------
interface multi_phase_addr_gen_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int STEP_WIDTH = 12,
    parameter int OFS_WIDTH  = 8,
    parameter int NUM_CH     = 2
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                         en;
    logic [STEP_WIDTH-1:0]        step;
    logic [1:0]                   mode;
    logic                         start;
    logic                         ofs_wr;
    logic [CH_W-1:0]              ofs_ch;
    logic [OFS_WIDTH-1:0]         ofs_data;
    logic [NUM_CH*ADDR_WIDTH-1:0] addr;
    logic                         wrap;
    logic                         busy;
    logic                         done;

    modport master (
        output en, step, mode, start, ofs_wr, ofs_ch, ofs_data,
        input  addr, wrap, busy, done
    );

    modport slave (
        input  en, step, mode, start, ofs_wr, ofs_ch, ofs_data,
        output addr, wrap, busy, done
    );
endinterface

// File: rtl/multi_phase_addr_gen.sv
// ---------------------------------------------------------------------------
// multi_phase_addr_gen
//
// Drives NUM_CH ROM read addresses from one shared fractional phase
// accumulator. Each channel adds its own runtime-writable offset to the master
// address. The accumulator can free-run with wrap-around, bounce between the
// ends of the table (ping-pong) or sweep once per start request (one-shot).
//
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset; overrides every other input
//   bus   slave modport of multi_phase_addr_gen_if (controls in, addr/status out)
//
// All outputs are registered. The address registers are loaded from the
// next-state accumulator and offsets, so a change made at an edge appears on
// addr straight after that same edge.
// ---------------------------------------------------------------------------
module multi_phase_addr_gen #(
    parameter int ADDR_WIDTH = 9,
    parameter int FRAC_WIDTH = 8,
    parameter int STEP_WIDTH = 12,
    parameter int OFS_WIDTH  = 8,
    parameter int NUM_CH     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    multi_phase_addr_gen_if.slave bus
);
    localparam int ACC_W = ADDR_WIDTH + FRAC_WIDTH;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic { IDLE = 1'b0, RUN = 1'b1 } state_t;
    typedef enum logic { DIR_UP = 1'b0, DIR_DOWN = 1'b1 } dir_t;

    logic [ACC_W-1:0]             acc_q, acc_d;
    dir_t                         dir_q, dir_d;
    state_t                       state_q, state_d;
    logic [OFS_WIDTH-1:0]         ofs_q [NUM_CH];
    logic [OFS_WIDTH-1:0]         ofs_d [NUM_CH];
    logic [NUM_CH*ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                         wrap_q, wrap_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;

    logic [ACC_W-1:0]             step_ext;
    logic [ACC_W-1:0]             sum;
    logic [ACC_W-1:0]             diff;
    logic                         carry;
    logic                         below;
    logic [ADDR_WIDTH-1:0]        m_next;

    // Next-state logic for accumulator, direction, burst state, offsets and
    // the registered outputs. The mode override at the bottom lets a mode
    // change cancel a running burst (silently) and reset the ping-pong
    // direction, whatever the enable is doing.
    always_comb begin
        acc_d   = acc_q;
        dir_d   = dir_q;
        state_d = state_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        ofs_d   = ofs_q;

        step_ext     = ACC_W'(bus.step);
        {carry, sum} = {1'b0, acc_q} + {1'b0, step_ext};
        diff         = acc_q - step_ext;
        below        = (acc_q < step_ext);

        case (bus.mode)
            2'b00: begin
                if (bus.en) begin
                    acc_d  = sum;
                    wrap_d = carry;
                end
            end
            2'b01: begin
                if (bus.en) begin
                    if (dir_q == DIR_UP) begin
                        // Overflow parks at the very top so the way down
                        // starts from the last address.
                        if (carry) begin
                            acc_d  = '1;
                            dir_d  = DIR_DOWN;
                            wrap_d = 1'b1;
                        end else begin
                            acc_d = sum;
                        end
                    end else begin
                        if (below) begin
                            acc_d  = '0;
                            dir_d  = DIR_UP;
                            wrap_d = 1'b1;
                        end else begin
                            acc_d = diff;
                        end
                    end
                end
            end
            2'b10: begin
                if (state_q == IDLE) begin
                    // The arming edge does not advance; start needs no enable.
                    acc_d = '0;
                    if (bus.start) begin
                        state_d = RUN;
                    end
                end else if (bus.en) begin
                    if (carry) begin
                        acc_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                        wrap_d  = 1'b1;
                    end else begin
                        acc_d = sum;
                    end
                end
            end
            default: begin
            end
        endcase

        if (bus.mode != 2'b10) begin
            state_d = IDLE;
        end
        if (bus.mode != 2'b01) begin
            dir_d = DIR_UP;
        end

        // Writes to a channel index beyond NUM_CH match no entry and drop out.
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.ofs_wr && (bus.ofs_ch == CH_W'(k))) begin
                ofs_d[k] = bus.ofs_data;
            end
        end

        m_next = acc_d[ACC_W-1:FRAC_WIDTH];
        addr_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            addr_d[k*ADDR_WIDTH +: ADDR_WIDTH] = m_next + ADDR_WIDTH'(ofs_d[k]);
        end

        busy_d = (state_d == RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            dir_q   <= DIR_UP;
            state_q <= IDLE;
            for (int k = 0; k < NUM_CH; k++) begin
                ofs_q[k] <= '0;
            end
            addr_q  <= '0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            dir_q   <= dir_d;
            state_q <= state_d;
            for (int k = 0; k < NUM_CH; k++) begin
                ofs_q[k] <= ofs_d[k];
            end
            addr_q  <= addr_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.addr = addr_q;
    assign bus.wrap = wrap_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_multi_phase_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_multi_phase_addr_gen
//
// Directed bench for multi_phase_addr_gen with three channels. Walks through
// reset, wrap mode with offsets, fractional steps, ping-pong turnarounds,
// one-shot bursts, offset writes and reset in the middle of a burst. Outputs
// are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_multi_phase_addr_gen;
    localparam int AW  = 9;
    localparam int FW  = 8;
    localparam int SW  = 12;
    localparam int OW  = 8;
    localparam int NCH = 3;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;

    multi_phase_addr_gen_if #(
        .ADDR_WIDTH(AW), .STEP_WIDTH(SW), .OFS_WIDTH(OW), .NUM_CH(NCH)
    ) bus ();

    multi_phase_addr_gen #(
        .ADDR_WIDTH(AW), .FRAC_WIDTH(FW), .STEP_WIDTH(SW),
        .OFS_WIDTH(OW), .NUM_CH(NCH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives all control inputs in one go.
    task automatic applyStimulus(input logic en, input int step, input logic [1:0] mode,
                                 input logic start, input logic ofs_wr,
                                 input int ofs_ch, input int ofs_data);
        bus.en       = en;
        bus.step     = SW'(step);
        bus.mode     = mode;
        bus.start    = start;
        bus.ofs_wr   = ofs_wr;
        bus.ofs_ch   = 2'(ofs_ch);
        bus.ofs_data = OW'(ofs_data);
    endtask

    // Advance one edge and land 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int chAddr(input int k);
        return int'(bus.addr[k*AW +: AW]);
    endfunction

    initial begin
        testsRun    = 0;
        testsFailed = 0;

        // Reset with an offset write pending: offsets must stay zero.
        rst = 1'b1;
        applyStimulus(1'b1, 256, 2'b00, 1'b0, 1'b1, 1, 99);
        tick();
        tick();
        checkOutput("rst addr0", chAddr(0), 0);
        checkOutput("rst addr1", chAddr(1), 0);
        checkOutput("rst addr2", chAddr(2), 0);
        checkOutput("rst wrap", int'(bus.wrap), 0);
        checkOutput("rst busy", int'(bus.busy), 0);
        checkOutput("rst done", int'(bus.done), 0);
        rst = 1'b0;
        applyStimulus(1'b0, 256, 2'b11, 1'b0, 1'b0, 0, 0);
        tick();
        checkOutput("rst ofs1 kept 0", chAddr(1), 0);

        // Wrap mode: ofs[1]=64 while disabled, then 512 whole-address advances.
        applyStimulus(1'b0, 256, 2'b00, 1'b0, 1'b1, 1, 64);
        tick();
        checkOutput("ofs wr addr0", chAddr(0), 0);
        checkOutput("ofs wr addr1", chAddr(1), 64);
        applyStimulus(1'b1, 256, 2'b00, 1'b0, 1'b0, 0, 0);
        for (int k = 1; k <= 512; k++) begin
            tick();
            checkOutput("wrap addr0", chAddr(0), k % 512);
            checkOutput("wrap addr1", chAddr(1), (k + 64) % 512);
            checkOutput("wrap pulse", int'(bus.wrap), (k == 512) ? 1 : 0);
        end
        tick();
        checkOutput("wrap pulse clr", int'(bus.wrap), 0);

        // Fractional steps, each starting from a zeroed accumulator (mode 10 idle).
        applyStimulus(1'b1, 128, 2'b10, 1'b0, 1'b0, 0, 0);
        tick();
        checkOutput("frac zero", chAddr(0), 0);
        applyStimulus(1'b1, 128, 2'b00, 1'b0, 1'b0, 0, 0);
        tick(); checkOutput("step128 a", chAddr(0), 0);
        tick(); checkOutput("step128 b", chAddr(0), 1);
        tick(); checkOutput("step128 c", chAddr(0), 1);
        tick(); checkOutput("step128 d", chAddr(0), 2);

        applyStimulus(1'b1, 384, 2'b10, 1'b0, 1'b0, 0, 0);
        tick();
        checkOutput("frac zero2", chAddr(0), 0);
        applyStimulus(1'b1, 384, 2'b00, 1'b0, 1'b0, 0, 0);
        tick(); checkOutput("step384 a", chAddr(0), 1);
        tick(); checkOutput("step384 b", chAddr(0), 3);
        tick(); checkOutput("step384 c", chAddr(0), 4);
        tick(); checkOutput("step384 d", chAddr(0), 6);

        applyStimulus(1'b1, 0, 2'b00, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("step0 addr0", chAddr(0), 6);
            checkOutput("step0 wrap", int'(bus.wrap), 0);
        end

        // Ping-pong from zero.
        applyStimulus(1'b1, 256, 2'b10, 1'b0, 1'b0, 0, 0);
        tick();
        applyStimulus(1'b1, 256, 2'b01, 1'b0, 1'b0, 0, 0);
        for (int k = 1; k <= 511; k++) begin
            tick();
            checkOutput("pp up addr0", chAddr(0), k);
            checkOutput("pp up wrap", int'(bus.wrap), 0);
        end
        tick();
        checkOutput("pp top addr0", chAddr(0), 511);
        checkOutput("pp top wrap", int'(bus.wrap), 1);
        for (int j = 1; j <= 511; j++) begin
            tick();
            checkOutput("pp dn addr0", chAddr(0), 511 - j);
            checkOutput("pp dn wrap", int'(bus.wrap), 0);
        end
        tick();
        checkOutput("pp bot addr0", chAddr(0), 0);
        checkOutput("pp bot wrap", int'(bus.wrap), 1);
        tick();
        checkOutput("pp reup addr0", chAddr(0), 1);
        checkOutput("pp reup wrap", int'(bus.wrap), 0);

        // One-shot: arm, ignore a second start, freeze with en low, finish.
        applyStimulus(1'b1, 256, 2'b10, 1'b1, 1'b0, 0, 0);
        tick();
        checkOutput("os arm busy", int'(bus.busy), 1);
        checkOutput("os arm addr0", chAddr(0), 0);
        applyStimulus(1'b1, 256, 2'b10, 1'b0, 1'b0, 0, 0);
        for (int k = 1; k <= 100; k++) begin
            tick();
            checkOutput("os run addr0", chAddr(0), k);
            checkOutput("os run busy", int'(bus.busy), 1);
        end
        applyStimulus(1'b1, 256, 2'b10, 1'b1, 1'b0, 0, 0);
        tick();
        checkOutput("os restart addr0", chAddr(0), 101);
        checkOutput("os restart busy", int'(bus.busy), 1);
        applyStimulus(1'b0, 256, 2'b10, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("os hold addr0", chAddr(0), 101);
            checkOutput("os hold busy", int'(bus.busy), 1);
        end
        applyStimulus(1'b1, 256, 2'b10, 1'b0, 1'b0, 0, 0);
        for (int k = 102; k <= 511; k++) begin
            tick();
            checkOutput("os run2 addr0", chAddr(0), k);
            checkOutput("os run2 done", int'(bus.done), 0);
        end
        tick();
        checkOutput("os end addr0", chAddr(0), 0);
        checkOutput("os end done", int'(bus.done), 1);
        checkOutput("os end wrap", int'(bus.wrap), 1);
        checkOutput("os end busy", int'(bus.busy), 0);
        tick();
        checkOutput("os after done", int'(bus.done), 0);
        checkOutput("os after wrap", int'(bus.wrap), 0);
        checkOutput("os after busy", int'(bus.busy), 0);
        checkOutput("os after addr0", chAddr(0), 0);

        // Offsets: ofs[2]=255 with addr0 climbing to 300 in 15-address steps.
        applyStimulus(1'b1, 3840, 2'b00, 1'b0, 1'b1, 2, 255);
        tick();
        applyStimulus(1'b1, 3840, 2'b00, 1'b0, 1'b0, 0, 0);
        for (int k = 2; k <= 20; k++) begin
            tick();
        end
        checkOutput("ofs addr0", chAddr(0), 300);
        checkOutput("ofs addr1", chAddr(1), 364);
        checkOutput("ofs addr2", chAddr(2), 43);
        applyStimulus(1'b0, 3840, 2'b00, 1'b0, 1'b1, 3, 7);
        tick();
        checkOutput("ofs ch3 addr0", chAddr(0), 300);
        checkOutput("ofs ch3 addr1", chAddr(1), 364);
        checkOutput("ofs ch3 addr2", chAddr(2), 43);

        // Reset in the middle of a burst at addr0=200.
        applyStimulus(1'b1, 256, 2'b10, 1'b1, 1'b0, 0, 0);
        tick();
        checkOutput("rb arm busy", int'(bus.busy), 1);
        applyStimulus(1'b1, 256, 2'b10, 1'b0, 1'b0, 0, 0);
        for (int k = 1; k <= 200; k++) begin
            tick();
        end
        checkOutput("rb pre addr0", chAddr(0), 200);
        rst = 1'b1;
        tick();
        checkOutput("rb addr0", chAddr(0), 0);
        checkOutput("rb addr1", chAddr(1), 0);
        checkOutput("rb addr2", chAddr(2), 0);
        checkOutput("rb busy", int'(bus.busy), 0);
        checkOutput("rb done", int'(bus.done), 0);
        checkOutput("rb wrap", int'(bus.wrap), 0);
        rst = 1'b0;
        applyStimulus(1'b0, 256, 2'b11, 1'b0, 1'b0, 0, 0);
        tick();
        checkOutput("rb post done", int'(bus.done), 0);
        checkOutput("rb post addr2", chAddr(2), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
